// File: rtl/ntt_unload_ctrl.sv
// ntt_unload_ctrl: streams the NTT result coefficients out of the 2*PE_NUMBER coefficient BRAMs.
// Latency: first dout_valid two clk edges after the edge that samples start; then one coefficient per cycle.
// Backpressure: dout_ready low stalls dout; reads are throttled so the 2-entry skid never overflows.
//
// Ports:
//   clk, reset   - sole clock; asynchronous active-high reset
//   start        - one-cycle pulse that begins an unload (ignored while busy)
//   raddr        - {2'b10, row} read address broadcast to every bank; holds when no read is issued
//   rdata        - concatenated bank read data, bank b at [b*DATA_SIZE_ARB +: DATA_SIZE_ARB]
//   dout/_valid/_ready/_last - coefficient stream; _last marks output position RING_SIZE-1
//   busy, done   - busy from start acceptance until done; done pulses after the last handshake
//
// Optional feature: define UNLOAD_BITREV_EN to emit coefficients in bit-reversed index order.

`ifndef RING_DEPTH
`define RING_DEPTH 10
`endif
`ifndef RING_SIZE
`define RING_SIZE 1024
`endif
`ifndef PE_DEPTH
`define PE_DEPTH 3
`endif
`ifndef PE_NUMBER
`define PE_NUMBER 8
`endif
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 16
`endif

module ntt_unload_ctrl (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  output logic [`RING_DEPTH-`PE_DEPTH+1:0]      raddr,
  input  logic [2*`PE_NUMBER*`DATA_SIZE_ARB-1:0] rdata,
  output logic [`DATA_SIZE_ARB-1:0]             dout,
  output logic                                  dout_valid,
  input  logic                                  dout_ready,
  output logic                                  dout_last,
  output logic                                  busy,
  output logic                                  done
);

  localparam int RD = `RING_DEPTH;      // coefficient index width
  localparam int DW = `DATA_SIZE_ARB;
  localparam int BW = `PE_DEPTH + 1;    // bank index width (2*PE_NUMBER banks)
  localparam int AW = `RING_DEPTH - `PE_DEPTH + 2;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t          r_state;
  logic [RD-1:0]   r_cnt;            // output position of the next read to issue
  logic [AW-1:0]   r_raddr;
  logic [BW-1:0]   r_bank;           // bank of the read whose data is on rdata now
  logic            r_inflight;       // rdata carries a returned read this cycle
  logic            r_inflight_last;  // ...and it is the final output position
  logic            r_busy;
  logic            r_done;

  // Two-entry skid: entry 0 is the head driving dout.
  logic [DW-1:0]   r_skid0_dat;
  logic [DW-1:0]   r_skid1_dat;
  logic            r_skid0_last;
  logic            r_skid1_last;
  logic [1:0]      r_occ;

  logic [RD-1:0]   w_k;              // coefficient index for output position r_cnt
  logic [RD-BW-1:0] w_row;
  logic [DW-1:0]   w_rsel;
  logic            w_pop;
  logic [2:0]      w_fill;
  logic            w_issue;

`ifdef UNLOAD_BITREV_EN
  always_comb begin
    w_k = '0;
    for (int i = 0; i < RD; i++) begin
      w_k[i] = r_cnt[RD-1-i];
    end
  end
`else
  assign w_k = r_cnt;
`endif

  assign w_row      = w_k[RD-1:BW];
  assign w_rsel     = rdata[r_bank*DW +: DW];
  assign dout_valid = (r_occ != 2'd0);
  assign w_pop      = dout_valid & dout_ready;

  // Slots committed after this edge: the head leaving on this cycle's handshake frees
  // its slot, which is what lets a held-high dout_ready stream one coefficient per cycle.
  assign w_fill  = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_state == READ) && (w_fill < 3'd2);

  assign raddr     = r_raddr;
  assign dout      = r_skid0_dat;
  assign dout_last = r_skid0_last & dout_valid;
  assign busy      = r_busy;
  assign done      = r_done;

  // Control FSM, read issue and the bank/last pipeline that travels with each read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_raddr         <= '0;
      r_bank          <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        // Row never fills the address below the region bits, hence the single zero pad.
        r_raddr         <= {2'b10, 1'b0, w_row};
        r_bank          <= w_k[BW-1:0];
        r_inflight_last <= &r_cnt;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= READ;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        READ: begin
          if (w_issue) begin
            if (&r_cnt) begin
              r_state <= DRAIN;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          // start is not looked at here, so a coincident start cannot restart.
          if (w_pop && r_skid0_last) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Skid buffer: returned data enters behind whatever is still waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skid0_dat  <= '0;
      r_skid1_dat  <= '0;
      r_skid0_last <= 1'b0;
      r_skid1_last <= 1'b0;
      r_occ        <= 2'd0;
    end else begin
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_skid0_dat  <= w_rsel;
            r_skid0_last <= r_inflight_last;
          end else begin
            r_skid1_dat  <= w_rsel;
            r_skid1_last <= r_inflight_last;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_skid0_dat  <= r_skid1_dat;
          r_skid0_last <= r_skid1_last;
          r_occ        <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_skid0_dat  <= w_rsel;
            r_skid0_last <= r_inflight_last;
          end else begin
            r_skid0_dat  <= r_skid1_dat;
            r_skid0_last <= r_skid1_last;
            r_skid1_dat  <= w_rsel;
            r_skid1_last <= r_inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_unload_ctrl.sv
`ifndef RING_DEPTH
`define RING_DEPTH 10
`endif
`ifndef RING_SIZE
`define RING_SIZE 1024
`endif
`ifndef PE_DEPTH
`define PE_DEPTH 3
`endif
`ifndef PE_NUMBER
`define PE_NUMBER 8
`endif
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 16
`endif

module tb_ntt_unload_ctrl;

  localparam int RD = `RING_DEPTH;
  localparam int N  = `RING_SIZE;
  localparam int DW = `DATA_SIZE_ARB;
  localparam int NB = 2 * `PE_NUMBER;
  localparam int AW = `RING_DEPTH - `PE_DEPTH + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          dout_ready = 1'b0;
  logic [AW-1:0] raddr;
  logic [NB*DW-1:0] rdata;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_last;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ntt_unload_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .raddr      (raddr),
    .rdata      (rdata),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy),
    .done       (done)
  );

  // Coefficient memory: value k held at coefficient k (bank k%NB, row k/NB, region 2'b10).
  // Data is available the cycle after the address register loads.
  always_comb begin
    rdata = '0;
    for (int b = 0; b < NB; b++) begin
      if (raddr[AW-1 -: 2] == 2'b10)
        rdata[b*DW +: DW] = DW'(int'(raddr[AW-3:0]) * NB + b);
      else
        rdata[b*DW +: DW] = '1;
    end
  end

  function automatic int exp_k(input int j);
    int r;
    r = j;
`ifdef UNLOAD_BITREV_EN
    r = 0;
    for (int i = 0; i < RD; i++)
      if (((j >> i) & 1) != 0) r = r | (1 << (RD - 1 - i));
`endif
    return r;
  endfunction

  function automatic int exp_raddr(input int j);
    return (2 << (AW - 2)) | (exp_k(j) / NB);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_raddr"}, 32'(raddr), 0);
    chk({tag, "_dout"},  32'(dout), 0);
    chk({tag, "_valid"}, 32'(dout_valid), 0);
    chk({tag, "_last"},  32'(dout_last), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
  endtask

  // Pulse start, then check the two-edge latency and the first two read addresses.
  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("lat0_valid", 32'(dout_valid), 0);
    tick;
    chk("lat1_valid", 32'(dout_valid), 0);
    chk("raddr_j0", 32'(raddr), exp_raddr(0));
    tick;
    chk("lat2_valid", 32'(dout_valid), 1);
    chk("first_dout", 32'(dout), exp_k(0));
    chk("raddr_j1", 32'(raddr), exp_raddr(1));
  endtask

  // mode 0: ready held high (valid must be continuous); mode 1: ready toggles 1,0,1,0.
  // restart_at: pulse start together with that coefficient's handshake.
  // abort_at: return right after that coefficient's handshake edge.
  task automatic stream(input int mode, input int restart_at, input int abort_at);
    int j = 0;
    int cyc = 0;
    logic stall_prev = 1'b0;
    logic [DW-1:0] held = '0;
    logic held_last = 1'b0;
    logic hs;
    while (j < N && cyc < 8 * N) begin
      dout_ready = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
      if (stall_prev) begin
        chk("stall_valid", 32'(dout_valid), 1);
        chk("stall_dout", 32'(dout), 32'(held));
        chk("stall_last", 32'(dout_last), 32'(held_last));
      end
      if (mode == 0) chk("stream_valid", 32'(dout_valid), 1);
      if (dout_valid) begin
        chk("dout", 32'(dout), exp_k(j));
        chk("dout_last", 32'(dout_last), 32'(j == N - 1));
      end
      hs         = dout_valid & dout_ready;
      stall_prev = dout_valid & ~dout_ready;
      held       = dout;
      held_last  = dout_last;
      if (hs && j == restart_at) start = 1'b1;
      if (hs) j++;
      tick;
      start = 1'b0;
      cyc++;
      if (abort_at >= 0 && j > abort_at) return;
    end
    chk("stream_count", 32'(j), N);
    chk("done_pulse", 32'(done), 1);
    chk("busy_fall", 32'(busy), 0);
    chk("valid_after", 32'(dout_valid), 0);
    tick;
    chk("done_single", 32'(done), 0);
  endtask

  initial begin
    // Reset state.
    #1;
    chk_all_zero("rst");
    tick;
    tick;
    reset = 1'b0;
    tick;
    chk_all_zero("idle");

    // Full stream, ready held high.
    dout_ready = 1'b1;
    do_start;
    stream(0, -1, -1);

    // Ready toggling 1,0,1,0.
    do_start;
    stream(1, -1, -1);

    // Consumer stalled for ~50 cycles: head holds coefficient 0, then full stream.
    dout_ready = 1'b0;
    do_start;
    for (int c = 0; c < 48; c++) begin
      chk("hold_valid", 32'(dout_valid), 1);
      chk("hold_dout", 32'(dout), exp_k(0));
      chk("hold_last", 32'(dout_last), 0);
      tick;
    end
    stream(0, -1, -1);

    // start re-pulsed mid-stream is ignored; single done, no restart afterwards.
    do_start;
    stream(0, 300, -1);
    tick;
    chk("no_restart_valid", 32'(dout_valid), 0);
    chk("no_restart_busy", 32'(busy), 0);

    // start coincident with the last handshake returns to idle without restarting.
    do_start;
    stream(0, N - 1, -1);
    tick;
    chk("coinc_valid", 32'(dout_valid), 0);
    chk("coinc_busy", 32'(busy), 0);

    // Reset mid-unload aborts at once; a fresh start gives the full stream.
    do_start;
    stream(0, -1, 500);
    chk("pre_abort_valid", 32'(dout_valid), 1);
    reset = 1'b1;
    #1;
    chk_all_zero("abort");
    tick;
    chk_all_zero("abort_hold");
    reset = 1'b0;
    tick;
    tick;
    chk("post_abort_valid", 32'(dout_valid), 0);
    chk("post_abort_busy", 32'(busy), 0);
    do_start;
    stream(0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
